// File: rtl/video_timing_gen.sv
// rtl/video_timing_gen.sv - raster timing generator with pixel fetch and colour-bar source
module video_timing_gen #(
  parameter int H_ACTIVE = 1280,
  parameter int H_FP     = 110,
  parameter int H_SYNC   = 40,
  parameter int H_BP     = 220,
  parameter int V_ACTIVE = 720,
  parameter int V_FP     = 5,
  parameter int V_SYNC   = 5,
  parameter int V_BP     = 20,
  parameter bit HS_POL   = 1'b1,
  parameter bit VS_POL   = 1'b1
) (
  input  logic        pclk,
  input  logic        reset,
  input  logic        enable,
  input  logic        pattern_en,
  output logic        pixel_req,
  output logic [10:0] pixel_x,
  output logic [9:0]  pixel_y,
  input  logic [23:0] pixel_data,
  output logic        frame_start,
  output logic        video_hsync,
  output logic        video_vsync,
  output logic        video_de,
  output logic [23:0] video_rgb
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int BAR_W   = H_ACTIVE / 8;

  localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
  localparam logic [10:0] H_ACT    = 11'(H_ACTIVE);
  localparam logic [10:0] H_SS     = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] H_SE     = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0]  V_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0]  V_SS     = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0]  V_SE     = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [10:0] BAR_LAST = 11'(BAR_W - 1);

  logic [10:0] h_cnt;
  logic [9:0]  v_cnt;
  logic [10:0] bar_cnt;
  logic [2:0]  bar_idx;
  logic        pat_mode;

  logic origin, de_c, hs_c, vs_c, pat_cur;

  logic       s1_de, s1_hs, s1_vs, s1_pat;
  logic [2:0] s1_bar;
  logic       d_de, d_hs, d_vs, d_pat;
  logic [2:0] d_bar;

  function automatic logic [23:0] bar_rgb(input logic [2:0] idx);
    case (idx)
      3'd0:    bar_rgb = 24'hFFFFFF;
      3'd1:    bar_rgb = 24'hFFFF00;
      3'd2:    bar_rgb = 24'h00FFFF;
      3'd3:    bar_rgb = 24'h00FF00;
      3'd4:    bar_rgb = 24'hFF00FF;
      3'd5:    bar_rgb = 24'hFF0000;
      3'd6:    bar_rgb = 24'h0000FF;
      default: bar_rgb = 24'h000000;
    endcase
  endfunction

  // At the origin the live pattern_en decides, so pixel (0,0) already uses the new frame's mode
  always_comb begin
    origin  = (h_cnt == '0) && (v_cnt == '0);
    de_c    = (h_cnt < H_ACT) && (v_cnt < V_ACT);
    hs_c    = (h_cnt >= H_SS) && (h_cnt < H_SE);
    vs_c    = (v_cnt >= V_SS) && (v_cnt < V_SE);
    pat_cur = origin ? pattern_en : pat_mode;
  end

  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      h_cnt    <= '0;
      v_cnt    <= '0;
      bar_cnt  <= '0;
      bar_idx  <= '0;
      pat_mode <= 1'b0;
    end else begin
      if (origin) pat_mode <= pattern_en;
      if (!enable) begin
        h_cnt   <= '0;
        v_cnt   <= '0;
        bar_cnt <= '0;
        bar_idx <= '0;
      end else if (h_cnt == H_LAST) begin
        h_cnt   <= '0;
        bar_cnt <= '0;
        bar_idx <= '0;
        v_cnt   <= (v_cnt == V_LAST) ? 10'd0 : v_cnt + 10'd1;
      end else begin
        h_cnt <= h_cnt + 11'd1;
        // Last bar never advances, so it soaks up the H_ACTIVE % 8 remainder
        if (bar_cnt == BAR_LAST && bar_idx != 3'd7) begin
          bar_cnt <= '0;
          bar_idx <= bar_idx + 3'd1;
        end else begin
          bar_cnt <= bar_cnt + 11'd1;
        end
      end
    end
  end

  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      pixel_req   <= 1'b0;
      frame_start <= 1'b0;
      pixel_x     <= '0;
      pixel_y     <= '0;
      s1_de       <= 1'b0;
      s1_hs       <= 1'b0;
      s1_vs       <= 1'b0;
      s1_pat      <= 1'b0;
      s1_bar      <= '0;
    end else begin
      pixel_req   <= enable && de_c && !pat_cur;
      frame_start <= enable && origin;
      pixel_x     <= h_cnt;
      pixel_y     <= v_cnt;
      s1_de       <= enable && de_c;
      s1_hs       <= enable && hs_c;
      s1_vs       <= enable && vs_c;
      s1_pat      <= pat_cur;
      s1_bar      <= bar_idx;
    end
  end

  // Holding slot that matches the source's one-cycle read latency
  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      d_de  <= 1'b0;
      d_hs  <= 1'b0;
      d_vs  <= 1'b0;
      d_pat <= 1'b0;
      d_bar <= '0;
    end else begin
      d_de  <= enable && s1_de;
      d_hs  <= enable && s1_hs;
      d_vs  <= enable && s1_vs;
      d_pat <= s1_pat;
      d_bar <= s1_bar;
    end
  end

  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      video_de    <= 1'b0;
      video_hsync <= ~HS_POL;
      video_vsync <= ~VS_POL;
      video_rgb   <= '0;
    end else begin
      video_de    <= d_de;
      video_hsync <= d_hs ? HS_POL : ~HS_POL;
      video_vsync <= d_vs ? VS_POL : ~VS_POL;
      if (!d_de)
        video_rgb <= '0;
      else if (d_pat)
        video_rgb <= bar_rgb(d_bar);
      else
        video_rgb <= pixel_data;
    end
  end

endmodule

// File: tb/tb_video_timing_gen.sv
// tb/tb_video_timing_gen.sv - directed self-checking bench for video_timing_gen on a 16x8 raster
module tb_video_timing_gen;

  localparam int HT = 16;
  localparam int FT = 128;

  logic        pclk = 1'b0;
  logic        reset;
  logic        enable;
  logic        pattern_en;
  logic [23:0] pixel_data;

  logic        pixel_req, frame_start, video_hsync, video_vsync, video_de;
  logic [10:0] pixel_x;
  logic [9:0]  pixel_y;
  logic [23:0] video_rgb;

  logic        n_pixel_req, n_frame_start, n_hsync, n_vsync, n_de;
  logic [10:0] n_pixel_x;
  logic [9:0]  n_pixel_y;
  logic [23:0] n_rgb;

  int n_tests = 0;
  int n_fail  = 0;
  int origin;
  int pat_frame;

  logic [23:0] bars [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                            24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

  always #5 pclk = ~pclk;

  video_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b1)
  ) dut (
    .pclk(pclk), .reset(reset), .enable(enable), .pattern_en(pattern_en),
    .pixel_req(pixel_req), .pixel_x(pixel_x), .pixel_y(pixel_y),
    .pixel_data(pixel_data), .frame_start(frame_start),
    .video_hsync(video_hsync), .video_vsync(video_vsync),
    .video_de(video_de), .video_rgb(video_rgb)
  );

  video_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HS_POL(1'b0), .VS_POL(1'b0)
  ) dut_n (
    .pclk(pclk), .reset(reset), .enable(enable), .pattern_en(pattern_en),
    .pixel_req(n_pixel_req), .pixel_x(n_pixel_x), .pixel_y(n_pixel_y),
    .pixel_data(pixel_data), .frame_start(n_frame_start),
    .video_hsync(n_hsync), .video_vsync(n_vsync),
    .video_de(n_de), .video_rgb(n_rgb)
  );

  // Pixel source with one-cycle read latency; junk when not requested
  always @(posedge pclk)
    pixel_data <= pixel_req ? {3'b000, pixel_y, pixel_x} : 24'hA5A5A5;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_model(input int c);
    int k, f, h, v;
    logic de, hs, vs;
    logic [23:0] rgb;
    k = c - origin;
    f = k / FT;
    k = k % FT;
    h = k % HT;
    v = k / HT;
    de = (h < 8) && (v < 4);
    check("stage1", {pixel_req, frame_start, pixel_x, pixel_y},
          {de && (f != pat_frame), k == 0, 11'(h), 10'(v)});
    check("stage1_n", {n_pixel_req, n_frame_start, n_pixel_x, n_pixel_y},
          {de && (f != pat_frame), k == 0, 11'(h), 10'(v)});
    k = c - origin - 2;
    if (k < 0) begin
      de = 1'b0; hs = 1'b0; vs = 1'b0; rgb = '0;
    end else begin
      f = k / FT;
      k = k % FT;
      h = k % HT;
      v = k / HT;
      de = (h < 8) && (v < 4);
      hs = (h >= 10) && (h < 13);
      vs = (v >= 5) && (v < 7);
      if (!de)                rgb = '0;
      else if (f == pat_frame) rgb = bars[h];
      else                    rgb = {3'b000, 10'(v), 11'(h)};
    end
    check("video", {video_de, video_hsync, video_vsync, video_rgb}, {de, hs, vs, rgb});
    check("video_n", {n_de, n_hsync, n_vsync, n_rgb}, {de, ~hs, ~vs, rgb});
  endtask

  initial begin
    int de_cnt, hs_cnt, vs_cnt, fs_cnt, de_rise, de_first, de_fall_c, hs_gap, vs_first;
    int fs_a, fs_b;
    logic p_de, p_hs, p_vs;

    reset = 1'b1;
    enable = 1'b1;
    pattern_en = 1'b0;
    repeat (3) @(negedge pclk);
    check("rst_req", pixel_req, 0);
    check("rst_fs", frame_start, 0);
    check("rst_de", video_de, 0);
    check("rst_x", pixel_x, 0);
    check("rst_y", pixel_y, 0);
    check("rst_rgb", video_rgb, 0);
    check("rst_hs", video_hsync, 0);
    check("rst_vs", video_vsync, 0);
    check("rst_hs_n", n_hsync, 1);
    check("rst_vs_n", n_vsync, 1);

    reset = 1'b0;
    origin = 0;
    pat_frame = 4;
    de_cnt = 0; hs_cnt = 0; vs_cnt = 0; fs_cnt = 0; de_rise = 0;
    de_first = -1; de_fall_c = -1; hs_gap = -1; vs_first = -1;
    p_de = 1'b0; p_hs = 1'b0; p_vs = 1'b0;

    for (int c = 0; c <= 804; c++) begin
      @(negedge pclk);
      check_model(c);
      if (c < 3 * FT) begin
        if (video_de) de_cnt++;
        if (video_hsync) hs_cnt++;
        if (video_vsync) vs_cnt++;
        if (frame_start) fs_cnt++;
        if (video_de && !p_de) begin
          de_rise++;
          if (de_first < 0) de_first = c;
        end
        if (!video_de && p_de && de_fall_c < 0) de_fall_c = c;
        if (video_hsync && !p_hs && hs_gap < 0 && de_fall_c >= 0) hs_gap = c - de_fall_c;
        if (video_vsync && !p_vs && vs_first < 0) vs_first = c;
        p_de = video_de; p_hs = video_hsync; p_vs = video_vsync;
      end
      if (c == 424) pattern_en = 1'b1;
      if (c == 600) pattern_en = 1'b0;
      if (c == 804) enable = 1'b0;
    end

    check("de_first", de_first, 2);
    check("de_cycles", de_cnt, 96);
    check("de_lines", de_rise, 12);
    check("hs_cycles", hs_cnt, 72);
    check("hs_gap", hs_gap, 2);
    check("vs_cycles", vs_cnt, 96);
    check("vs_start", vs_first, 82);
    check("fs_count", fs_cnt, 3);

    for (int d = 1; d <= 10; d++) begin
      @(negedge pclk);
      check("dis_req", pixel_req, 0);
      check("dis_fs", frame_start, 0);
      if (d >= 2) check("dis_de", video_de, 0);
      if (d == 10) enable = 1'b1;
    end

    origin = 815;
    pat_frame = -1;
    fs_a = -1; fs_b = -1;
    for (int c = 815; c <= 815 + FT + 4; c++) begin
      @(negedge pclk);
      check_model(c);
      if (frame_start) begin
        if (fs_a < 0) fs_a = c;
        else if (fs_b < 0) fs_b = c;
      end
    end
    check("reen_fs", fs_a, 815);
    check("reen_period", fs_b - fs_a, FT);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
